// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Captured access type.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Default memory geometry: 256 words.
    localparam int DEF_DEPTH = 256;
    localparam int IDX_W     = $clog2(DEF_DEPTH);

endpackage

// File: rtl/data_mem_resp_if.sv
// MEM-stage access bus between the pipeline (master) and the memory responder (slave).
interface data_mem_resp_if #(
    parameter int DATA_W = 32
);
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_stall;
    logic              resp_valid;
    logic              err;

    modport master (
        output mem_read,
        output mem_write,
        output addr,
        output wdata,
        input  rdata,
        input  mem_stall,
        input  resp_valid,
        input  err
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  addr,
        input  wdata,
        output rdata,
        output mem_stall,
        output resp_valid,
        output err
    );
endinterface

// File: rtl/data_mem_array.sv
// Word storage: synchronous write, asynchronous read, contents not reset.
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the write word on the commit edge; the array has no reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_resp.sv
// Fixed-latency data-memory responder: stalls the pipeline while an access
// is in flight, then presents a one-cycle response with read data or error.
module data_mem_resp
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1 << IDX_W,
    parameter int LATENCY = 3
) (
    input  logic           clock,
    input  logic           reset,
    data_mem_resp_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    op_e               op_q,         op_d;
    logic [AW-1:0]     idx_q,        idx_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] rdata_q,      rdata_d;
    logic              err_q,        err_d;
    logic              resp_valid_q, resp_valid_d;

    logic              req_s;
    logic              both_s;
    logic              misalign_s;
    logic              out_of_range_s;
    logic              illegal_s;
    logic              stall_s;
    logic              arr_we_s;
    logic [DATA_W-1:0] arr_rdata_s;

    // Legality of the presented request: word-aligned, inside the array, one op only.
    assign req_s          = bus.mem_read | bus.mem_write;
    assign both_s         = bus.mem_read & bus.mem_write;
    assign misalign_s     = (bus.addr[1:0] != 2'b00);
    assign out_of_range_s = (bus.addr[DATA_W-1:AW+2] != '0);
    assign illegal_s      = both_s | misalign_s | out_of_range_s;

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clock   (clock),
        .we_i    (arr_we_s),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata_s)
    );

    // Next-state, capture and commit decisions; stall is the only combinational output.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        stall_s      = 1'b0;
        arr_we_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    stall_s = 1'b1;
                    op_d    = bus.mem_write ? OP_WR : OP_RD;
                    idx_d   = bus.addr[AW+1:2];
                    wdata_d = bus.wdata;
                    if (illegal_s) begin
                        // Rejected access: answer next cycle, array untouched.
                        state_d      = RESP;
                        cnt_d        = {CNT_W{1'b0}};
                        err_d        = 1'b1;
                        rdata_d      = {DATA_W{1'b0}};
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                        err_d   = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            BUSY: begin
                stall_s = 1'b1;
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    // Commit edge: the write lands before RESP so a following read sees it.
                    state_d      = RESP;
                    err_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    if (op_q == OP_WR) begin
                        arr_we_s = 1'b1;
                    end else begin
                        rdata_d = arr_rdata_s;
                    end
                end
            end

            RESP: begin
                // The request may still be asserted here; it is deliberately ignored.
                state_d = IDLE;
                err_d   = 1'b0;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
                err_d   = 1'b0;
            end
        endcase
    end

    // FSM, counter, capture and response registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            op_q         <= OP_RD;
            idx_q        <= {AW{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            rdata_q      <= {DATA_W{1'b0}};
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign bus.mem_stall  = stall_s;
    assign bus.rdata      = rdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: two instances (latency 3 and latency 1) driven by
// directed and random accesses, checked by a queue-based scoreboard.
module tb_data_mem_resp;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        longint      issue;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    data_mem_resp_if #(.DATA_W(32)) bus3 ();
    data_mem_resp_if #(.DATA_W(32)) bus1 ();

    data_mem_resp #(.DATA_W(32), .DEPTH(256), .LATENCY(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    data_mem_resp #(.DATA_W(32), .DEPTH(256), .LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    // Lane 0 = latency 3 instance, lane 1 = latency 1 instance.
    logic        rd_s [2];
    logic        wr_s [2];
    logic [31:0] ad_s [2];
    logic [31:0] wd_s [2];
    logic        st_o [2];
    logic        rv_o [2];
    logic        er_o [2];
    logic [31:0] rd_o [2];

    assign bus3.mem_read  = rd_s[0];
    assign bus3.mem_write = wr_s[0];
    assign bus3.addr      = ad_s[0];
    assign bus3.wdata     = wd_s[0];
    assign bus1.mem_read  = rd_s[1];
    assign bus1.mem_write = wr_s[1];
    assign bus1.addr      = ad_s[1];
    assign bus1.wdata     = wd_s[1];
    assign st_o[0] = bus3.mem_stall;
    assign rv_o[0] = bus3.resp_valid;
    assign er_o[0] = bus3.err;
    assign rd_o[0] = bus3.rdata;
    assign st_o[1] = bus1.mem_stall;
    assign rv_o[1] = bus1.resp_valid;
    assign er_o[1] = bus1.err;
    assign rd_o[1] = bus1.rdata;

    // Reference model: word contents, last returned data, written-word lists.
    logic [31:0] model   [2][256];
    bit          known   [2][256];
    logic [31:0] last_rd [2];
    int          wr_idx  [2][$];
    exp_t        sbq     [2][$];

    longint      cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          timeouts = 0;
    int          timeouts_seen = 0;
    int          run [2];
    bit          idle_chk [2];
    logic [31:0] idle_rdata [2];
    bit          end_req = 1'b0;
    bit          end_done = 1'b0;

    // Cycle counter, advanced on every active edge.
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int g,
                                input logic [31:0] act, input logic [31:0] exp_v);
        vectors = vectors + 1;
        if (act !== exp_v) begin
            miscompares = miscompares + 1;
            $display("FAIL %s lane%0d: got %h, expected %h (cycle %0d)", nm, g, act, exp_v, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on each response and checks timing and data.
    initial begin
        exp_t e;
        run[0] = 0;
        run[1] = 0;
        forever begin
            @(negedge clock);
            for (int g = 0; g < 2; g++) begin
                if (!reset) begin
                    run[g] = 0;
                    chk("rst_stall", g, 32'(st_o[g]), 32'h0);
                    chk("rst_valid", g, 32'(rv_o[g]), 32'h0);
                    chk("rst_err",   g, 32'(er_o[g]), 32'h0);
                    chk("rst_rdata", g, rd_o[g],      32'h0);
                end else begin
                    if (st_o[g]) begin
                        run[g] = run[g] + 1;
                    end else begin
                        if (rv_o[g]) begin
                            chk("resp_expected", g, 32'(sbq[g].size() > 0), 32'h1);
                            if (sbq[g].size() > 0) begin
                                e = sbq[g].pop_front();
                                chk("resp_err",     g, 32'(er_o[g]), 32'(e.err));
                                chk("resp_rdata",   g, rd_o[g], e.rdata);
                                chk("resp_latency", g, 32'(cyc - e.issue), 32'(e.lat));
                                chk("stall_cycles", g, 32'(run[g]), 32'(e.lat));
                            end
                        end else begin
                            chk("err_without_valid", g, 32'(er_o[g]), 32'h0);
                        end
                        run[g] = 0;
                    end
                    if (idle_chk[g]) begin
                        chk("idle_stall", g, 32'(st_o[g]), 32'h0);
                        chk("idle_valid", g, 32'(rv_o[g]), 32'h0);
                        chk("idle_rdata", g, rd_o[g], idle_rdata[g]);
                    end
                end
            end
            if (timeouts != timeouts_seen) begin
                chk("resp_timeout", 0, 32'(timeouts), 32'(timeouts_seen));
                timeouts_seen = timeouts;
            end
            if (end_req && !end_done) begin
                chk("leftover_expected", 0, 32'(sbq[0].size()), 32'h0);
                chk("leftover_expected", 1, 32'(sbq[1].size()), 32'h0);
                end_done = 1'b1;
            end
        end
    end

    // One access on lane g; the model predicts the response from the memory rules.
    task automatic access(input int g, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input bit hold);
        exp_t e;
        bit   legal;
        int   n;
        int   lat;
        int   w;
        @(posedge clock);
        #1;
        rd_s[g] = rd;
        wr_s[g] = wr;
        ad_s[g] = a;
        wd_s[g] = d;
        legal = !(rd && wr) && (a[1:0] == 2'b00) && (a < 32'h400);
        lat   = (g == 0) ? 3 : 1;
        w     = int'(a[9:2]);
        if (!legal) begin
            last_rd[g] = 32'h0;
        end else if (wr) begin
            if (!known[g][w]) wr_idx[g].push_back(w);
            model[g][w] = d;
            known[g][w] = 1'b1;
        end else begin
            last_rd[g] = model[g][w];
        end
        e.rdata = last_rd[g];
        e.err   = !legal;
        e.issue = cyc;
        e.lat   = legal ? lat + 1 : 1;
        sbq[g].push_back(e);
        n = 0;
        do begin
            @(negedge clock);
            n = n + 1;
        end while (!rv_o[g] && n < 20);
        if (!rv_o[g]) timeouts = timeouts + 1;
        if (!hold) begin
            @(posedge clock);
            #1;
            rd_s[g] = 1'b0;
            wr_s[g] = 1'b0;
        end
    endtask

    // Stimulus: directed scenarios first, then randomized traffic on both lanes.
    initial begin
        int          lane;
        int          nxt;
        int          kind;
        bit          hold;
        logic [31:0] a;
        int          n;

        for (int g = 0; g < 2; g++) begin
            rd_s[g] = 1'b0; wr_s[g] = 1'b0; ad_s[g] = 32'h0; wd_s[g] = 32'h0;
            last_rd[g] = 32'h0; idle_chk[g] = 1'b0; idle_rdata[g] = 32'h0;
        end
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Write then read back at latency 3.
        access(0, 1'b0, 1'b1, 32'h40, 32'h12345678, 1'b0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

        // Back-to-back: read of 0x40 held through RESP, then read of 0x44.
        access(0, 1'b0, 1'b1, 32'h44, 32'hCAFE0044, 1'b0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1);
        access(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);

        // Illegal accesses, then confirm the word at 0x40 is unchanged.
        access(0, 1'b1, 1'b0, 32'h41, 32'h0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0);
        access(0, 1'b1, 1'b1, 32'h40, 32'hBAD0BAD0, 1'b0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);

        // Reset in the middle of a write: the write must be abandoned.
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
        @(posedge clock);
        #1;
        rd_s[0] = 1'b0; wr_s[0] = 1'b1; ad_s[0] = 32'h10; wd_s[0] = 32'hDEADBEEF;
        repeat (2) @(posedge clock);
        #1;
        wr_s[0]    = 1'b0;
        reset      = 1'b0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

        // Latency 1 lane.
        access(1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 1'b0);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Idle for 20 cycles: nothing moves, rdata holds.
        @(posedge clock);
        #1;
        idle_rdata[0] = last_rd[0];
        idle_rdata[1] = last_rd[1];
        idle_chk[0]   = 1'b1;
        idle_chk[1]   = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        idle_chk[0] = 1'b0;
        idle_chk[1] = 1'b0;

        // Randomized traffic.
        lane = 0;
        for (int i = 0; i < 160; i++) begin
            nxt  = int'($urandom_range(0, 1));
            hold = (nxt == lane) && ($urandom_range(0, 2) == 0);
            kind = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 63)) << 2;
            if (kind == 0) begin
                a = a | 32'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 1) access(lane, 1'b1, 1'b0, a, $urandom, hold);
                else                           access(lane, 1'b0, 1'b1, a, $urandom, hold);
            end else if (kind == 1) begin
                a = $urandom & 32'hFFFF_FFFC;
                if (a < 32'h400) a = a | 32'h400;
                access(lane, 1'b1, 1'b0, a, $urandom, hold);
            end else if (kind == 2) begin
                access(lane, 1'b1, 1'b1, a, $urandom, hold);
            end else if (kind >= 6 && wr_idx[lane].size() > 0) begin
                a = 32'(wr_idx[lane][$urandom_range(0, wr_idx[lane].size() - 1)]) << 2;
                access(lane, 1'b1, 1'b0, a, $urandom, hold);
            end else begin
                access(lane, 1'b0, 1'b1, a, $urandom, hold);
            end
            if (hold) begin
                lane = nxt;
            end else begin
                lane = nxt;
                repeat ($urandom_range(0, 2)) @(posedge clock);
            end
        end
        @(posedge clock);
        #1;
        rd_s[0] = 1'b0; wr_s[0] = 1'b0; rd_s[1] = 1'b0; wr_s[1] = 1'b0;

        repeat (3) @(posedge clock);
        end_req = 1'b1;
        n = 0;
        while (!end_done && n < 10) begin
            @(negedge clock);
            n = n + 1;
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Word-addressed data-memory responder: the memory end of the pipeline's MEM-stage access interface (`mem_read` / `mem_write` / address / write data). It serves each access with a fixed, parameterised latency. While the access is in flight it holds `mem_stall` high so the hazard logic freezes the pipeline. It returns read data with a one-cycle `resp_valid` strobe, and flags misaligned or out-of-range accesses with `err`.

## Interface
- `DATA_W`, 32, data and address width.
- `DEPTH`, 256, number of words; power of two.
- `LATENCY`, 3, BUSY cycles per legal access; must be ≥ 1.
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low.
- `mem_read` input 1: read request from EX/MEM; held stable while `mem_stall` = 1.
- `mem_write` input 1: write request; same holding rule.
- `addr` input DATA_W: byte address; word index = `addr[log2(DEPTH)+1:2]`.
- `wdata` input DATA_W: write data.
- `rdata` output DATA_W: read data; valid when `resp_valid` = 1, otherwise holds its value.
- `mem_stall` output 1: freeze request to the hazard unit (PC, IF/ID and ID/EX hold).
- `resp_valid` output 1: one-cycle completion strobe for reads and writes.
- `err` output 1: qualifies `resp_valid`; access was illegal and was not performed.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - No request: stay IDLE, `mem_stall` = 0.
  - Request (`mem_read` | `mem_write`): `mem_stall` = 1 combinationally in the same cycle. Capture op, word index, `wdata`.
- **Illegal request.** Any of the following goes directly to RESP with `err` = 1 on the next edge:
  - `addr[1:0]` ≠ 0;
  - `addr` ≥ 4·DEPTH;
  - both `mem_read` and `mem_write` asserted.
- **Legal request.** Go to BUSY and load `cnt` = LATENCY-1.
- **BUSY**
  - `mem_stall` = 1.
  - `cnt` ≠ 0: decrement.
  - `cnt` = 0: commit on that edge (write the array, or register array data into `rdata`), then go to RESP.
- **RESP**
  - `mem_stall` = 0, `resp_valid` = 1, `err` as captured. Request inputs are ignored.
  - Always returns to IDLE on the next edge. This guarantees the still-present request is not re-accepted while the pipeline advances.
- **Error response:** `rdata` is forced to 0 and the array is untouched.
- **Write response:** `rdata` is unchanged.
- **Array:** not reset; contents are undefined until written.
- **Reset**
  - Values on assertion: state IDLE, `cnt` 0, `rdata` 0, `resp_valid` 0, `err` 0, `mem_stall` 0.
  - Reset during BUSY abandons the access. A write whose commit edge has not occurred is not performed.

## Timing
- Request first seen in cycle 0 (IDLE).
- Legal access:
  - `mem_stall` high in cycles 0 … LATENCY.
  - RESP in cycle LATENCY+1, with `resp_valid` and `rdata` valid there.
  - Request-to-data: LATENCY+1 cycles.
- Illegal access:
  - `mem_stall` high in cycle 0 only.
  - RESP in cycle 1.
- Back-to-back: the next request can be sampled in cycle LATENCY+2. Minimum spacing is LATENCY+2 cycles per legal access.
- Read-after-write to the same word returns the new data; the write commits before RESP.
- `mem_stall` is the only combinational output (from `mem_read`, `mem_write` and state). All other outputs are registered.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, BUSY, RESP);
  - op encoding (OP_RD, OP_WR);
  - localparam `IDX_W` = log2(DEPTH).
- Sub-module `data_mem_array`: DEPTH × DATA_W storage with synchronous write and asynchronous read, instantiated once.
- Top-level `data_mem_resp` holds:
  - the FSM;
  - the latency counter;
  - capture registers;
  - legality checks;
  - `rdata` / `err` registers.

## Test plan
- **Reset:** drive `reset` low mid-run → all outputs 0, state IDLE. Write 0xDEADBEEF to addr 0x10 at LATENCY=3, assert reset at cycle 2 → a subsequent read of 0x10 must not return 0xDEADBEEF. Pre-seed the word with 0x0 first.
- **Write/read, LATENCY=3:** write 0x12345678 to 0x40, then read 0x40. Each access must show:
  - `mem_stall` high for exactly 4 cycles;
  - `resp_valid` in cycle 4;
  - on the read, `rdata` = 0x12345678 and `err` = 0.
- **Back-to-back:** hold a read of 0x40 across the RESP cycle, then present a read of 0x44 → exactly one response per request, second response in cycle 4 after the new request.
- **Errors**, each must give `err` = 1 in cycle 1, `rdata` = 0, and no array change:
  - read of 0x41 (misaligned);
  - read of 0x400 (out of range, DEPTH=256);
  - simultaneous read+write to 0x40.
- **LATENCY=1:** write then read 0x0 → `mem_stall` high 2 cycles per access, data 0xA5A5A5A5 returned.
- **Idle:** no requests for 20 cycles → `mem_stall`, `resp_valid` and `err` stay 0, and `rdata` keeps its last value.
